interrupt_controller: RTL and testbench

Collects external interrupt lines, latches them as pending, masks and prioritises them, and sequences delivery of the virtual CALL_ISR instruction into the decode stage. It drives the decode unit's `irq` input exactly on an instruction boundary, then tracks the interrupt through CALL_ISR write-back and the matching RETI. It sits between the peripherals, the I/O register space and the pipeline front end.

---
 rtl/interrupt_controller.sv | 145 ++++++++++++++
 tb/tb_interrupt_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Edge-latched, masked, lowest-index-first interrupt sequencer; irq rises two cycles after a line edge.
// No backpressure: irq waits in REQUEST for instr_boundary, then delivery waits for call_isr_ack and reti_done.
module interrupt_controller #(
    parameter int          IRQ_COUNT   = 4,
    parameter logic [9:0]  VECTOR_BASE = 10'h001,
    parameter logic [5:0]  MASK_ADDR   = 6'h3B,
    parameter logic [5:0]  PEND_ADDR   = 6'h3A
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IRQ_COUNT-1:0] irq_lines,
    input  logic                 sreg_i,
    input  logic                 instr_boundary,
    input  logic                 call_isr_ack,
    input  logic                 reti_done,
    input  logic [5:0]           io_addr,
    input  logic                 io_wr,
    input  logic [7:0]           io_data_in,
    output logic [7:0]           io_data_out,
    output logic                 irq,
    output logic [9:0]           isr_vector,
    output logic [2:0]           irq_id
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_ACK,
        IN_SERVICE
    } state_t;

    state_t               state_q, state_d;
    logic [IRQ_COUNT-1:0] prev_q, prev_d;
    logic [IRQ_COUNT-1:0] pending_q, pending_d;
    logic [IRQ_COUNT-1:0] mask_q, mask_d;
    logic [9:0]           isr_vector_q, isr_vector_d;
    logic [2:0]           irq_id_q, irq_id_d;

    logic [IRQ_COUNT-1:0] active;
    logic [IRQ_COUNT-1:0] edge_set;
    logic [IRQ_COUNT-1:0] wr_clear;
    logic [IRQ_COUNT-1:0] ack_clear;
    logic [IRQ_COUNT-1:0] id_onehot;
    logic [2:0]           winner;
    logic                 id_active;
    logic                 pend_wr;
    logic                 mask_wr;
    logic                 unused_data_bits;

    assign unused_data_bits = ^io_data_in;

    assign active    = pending_q & mask_q;
    assign edge_set  = irq_lines & ~prev_q;
    assign pend_wr   = io_wr && (io_addr == PEND_ADDR);
    assign mask_wr   = io_wr && (io_addr == MASK_ADDR);
    assign id_onehot = IRQ_COUNT'(1) << irq_id_q;
    assign id_active = |(active & id_onehot);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        winner = 3'd0;
        for (int k = IRQ_COUNT - 1; k >= 0; k--) begin
            if (active[k]) begin
                winner = 3'(k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        isr_vector_d = isr_vector_q;
        irq_id_d     = irq_id_q;
        ack_clear    = '0;
        irq          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sreg_i && (|active)) begin
                    irq_id_d     = winner;
                    isr_vector_d = VECTOR_BASE + {7'd0, winner};
                    state_d      = REQUEST;
                end
            end
            REQUEST: begin
                // Withdrawal takes precedence so a stale request never reaches decode.
                if (!sreg_i || !id_active) begin
                    state_d = IDLE;
                end else if (instr_boundary) begin
                    irq     = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (call_isr_ack) begin
                    ack_clear = id_onehot;
                    state_d   = IN_SERVICE;
                end
            end
            IN_SERVICE: begin
                if (reti_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clears are applied before sets so a same-cycle edge always survives.
    always_comb begin
        wr_clear  = pend_wr ? io_data_in[IRQ_COUNT-1:0] : '0;
        pending_d = (pending_q & ~(wr_clear | ack_clear)) | edge_set;
        mask_d    = mask_wr ? io_data_in[IRQ_COUNT-1:0] : mask_q;
        prev_d    = irq_lines;
    end

    always_comb begin
        io_data_out = 8'h00;
        if (io_addr == MASK_ADDR) begin
            io_data_out = 8'(mask_q);
        end else if (io_addr == PEND_ADDR) begin
            io_data_out = 8'(pending_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            isr_vector_q <= 10'd0;
            irq_id_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            isr_vector_q <= isr_vector_d;
            irq_id_q     <= irq_id_d;
        end
    end

    assign isr_vector = isr_vector_q;
    assign irq_id     = irq_id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus random traffic, every cycle compared against a delivery-stage reference model.
module tb_interrupt_controller;

    localparam logic [5:0] PEND = 6'h3A;
    localparam logic [5:0] MASK = 6'h3B;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_lines;
    logic       sreg_i, instr_boundary, call_isr_ack, reti_done;
    logic [5:0] io_addr;
    logic       io_wr;
    logic [7:0] io_data_in;
    logic [7:0] io_data_out;
    logic       irq;
    logic [9:0] isr_vector;
    logic [2:0] irq_id;

    interrupt_controller dut (
        .clk            (clk),
        .reset          (reset),
        .irq_lines      (irq_lines),
        .sreg_i         (sreg_i),
        .instr_boundary (instr_boundary),
        .call_isr_ack   (call_isr_ack),
        .reti_done      (reti_done),
        .io_addr        (io_addr),
        .io_wr          (io_wr),
        .io_data_in     (io_data_in),
        .io_data_out    (io_data_out),
        .irq            (irq),
        .isr_vector     (isr_vector),
        .irq_id         (irq_id)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: stage 0 idle, 1 requested, 2 delivered awaiting ack, 3 handler running.
    bit [7:0] m_pend, m_mask, m_prev;
    int       m_stage, m_id, m_vec;

    logic       last_irq;
    logic [9:0] last_vec;
    logic [2:0] last_id;
    logic [7:0] last_io;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_prev = 0;
        m_stage = 0; m_id = 0; m_vec = 0;
    endtask

    task automatic model_update();
        bit [7:0] act, set, clr;
        int nid;
        act = m_pend & m_mask;
        set = 8'(irq_lines) & ~m_prev;
        clr = 8'h00;
        if (io_wr && io_addr == PEND) clr = io_data_in & 8'h0F;
        if (m_stage == 2 && call_isr_ack) clr[m_id] = 1'b1;
        case (m_stage)
            0: if (sreg_i && act != 0) begin
                nid = 0;
                while (!act[nid]) nid++;
                m_id = nid;
                m_vec = (1 + nid) % 1024;
                m_stage = 1;
            end
            1: if (!sreg_i || !act[m_id]) m_stage = 0;
               else if (instr_boundary) m_stage = 2;
            2: if (call_isr_ack) m_stage = 3;
            3: if (reti_done) m_stage = 0;
            default: m_stage = 0;
        endcase
        m_pend = ((m_pend & ~clr) | set) & 8'h0F;
        if (io_wr && io_addr == MASK) m_mask = io_data_in & 8'h0F;
        m_prev = 8'(irq_lines);
    endtask

    function automatic bit [7:0] model_io();
        if (io_addr == MASK) return m_mask;
        if (io_addr == PEND) return m_pend;
        return 8'h00;
    endfunction

    function automatic bit model_irq();
        bit [7:0] act;
        act = m_pend & m_mask;
        return (m_stage == 1) && sreg_i && act[m_id] && instr_boundary;
    endfunction

    // Inputs already applied: compare this cycle's outputs, then clock the DUT and the model.
    task automatic step();
        #2;
        last_irq = irq; last_vec = isr_vector; last_id = irq_id; last_io = io_data_out;
        chk("irq", 32'(irq), 32'(model_irq()));
        chk("isr_vector", 32'(isr_vector), 32'(m_vec));
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("io_data_out", 32'(io_data_out), 32'(model_io()));
        @(posedge clk);
        if (reset) model_reset();
        else model_update();
        #1;
    endtask

    task automatic quiet();
        irq_lines = 4'h0; call_isr_ack = 0; reti_done = 0;
        io_wr = 0; io_addr = 6'h00; io_data_in = 8'h00;
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        io_addr = a; io_data_in = d; io_wr = 1; step(); io_wr = 0;
    endtask

    task automatic wait_irq(input string tag);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_irq) begin found = 1; break; end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic ack_and_return();
        call_isr_ack = 1; step(); call_isr_ack = 0;
        reti_done = 1; step(); reti_done = 0;
    endtask

    initial begin
        reset = 1; sreg_i = 0; instr_boundary = 0;
        quiet();
        model_reset();
        #1;
        io_addr = MASK; #1;
        chk("reset_imsk", 32'(io_data_out), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        step(); step();
        reset = 0;
        for (int i = 0; i < 6; i++) step();

        // Single source, boundary always open.
        io_write(MASK, 8'h01);
        sreg_i = 1; instr_boundary = 1;
        irq_lines = 4'b0001; step();
        irq_lines = 4'b0000; step();
        chk("s1_no_irq_n1", 32'(last_irq), 32'd0);
        step();
        chk("s1_irq_n2", 32'(last_irq), 32'd1);
        chk("s1_vec", 32'(last_vec), 32'h001);
        chk("s1_id", 32'(last_id), 32'd0);
        step();
        chk("s1_one_pulse", 32'(last_irq), 32'd0);
        ack_and_return();

        // Simultaneous edges on lines 3 and 1.
        io_write(MASK, 8'h0F);
        irq_lines = 4'b1010; step(); irq_lines = 4'b0000;
        wait_irq("s2_first_seen");
        chk("s2_first_vec", 32'(last_vec), 32'h002);
        call_isr_ack = 1; step(); call_isr_ack = 0;
        io_addr = PEND; step();
        chk("s2_ipend_between", 32'(last_io), 32'h08);
        reti_done = 1; step(); reti_done = 0;
        wait_irq("s2_second_seen");
        chk("s2_second_vec", 32'(last_vec), 32'h004);
        ack_and_return();

        // Global enable low blocks delivery.
        sreg_i = 0;
        irq_lines = 4'b0100; step(); irq_lines = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s3_blocked", 32'(last_irq), 32'd0);
        end
        sreg_i = 1; step();
        chk("s3_not_yet", 32'(last_irq), 32'd0);
        step();
        chk("s3_irq", 32'(last_irq), 32'd1);
        chk("s3_vec", 32'(last_vec), 32'h003);
        ack_and_return();

        // Request withdrawn before a boundary arrives.
        instr_boundary = 0;
        irq_lines = 4'b0100; step(); irq_lines = 4'b0000;
        step(); step();
        sreg_i = 0; step();
        io_addr = PEND; step();
        chk("s4_still_pending", 32'(last_io), 32'h04);
        chk("s4_no_irq", 32'(last_irq), 32'd0);
        sreg_i = 1; instr_boundary = 1;
        wait_irq("s4_redelivered");
        ack_and_return();

        // Write-1-to-clear racing an edge; unmapped read.
        sreg_i = 0;
        irq_lines = 4'b0001; io_write(PEND, 8'h01); irq_lines = 4'b0000;
        io_addr = PEND; step();
        chk("s5_set_wins", 32'(last_io), 32'h01);
        io_write(PEND, 8'h01);
        io_addr = PEND; step();
        chk("s5_cleared", 32'(last_io), 32'h00);
        io_addr = 6'h10; step();
        chk("s5_unmapped", 32'(last_io), 32'h00);

        // Reset while waiting for the CALL_ISR acknowledge.
        sreg_i = 1;
        irq_lines = 4'b0010; step(); irq_lines = 4'b0000;
        wait_irq("s6_delivered");
        io_addr = PEND;
        #1 reset = 1;
        model_reset();
        #1;
        chk("s6_rst_irq", 32'(irq), 32'd0);
        chk("s6_rst_ipend", 32'(io_data_out), 32'h00);
        chk("s6_rst_vec", 32'(isr_vector), 32'h000);
        step();
        reset = 0;
        io_addr = MASK; step();
        chk("s6_rst_imsk", 32'(last_io), 32'h00);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("s6_no_delivery", 32'(last_irq), 32'd0);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            irq_lines      = 4'($urandom_range(0, 15));
            sreg_i         = ($urandom_range(0, 3) != 0);
            instr_boundary = $urandom_range(0, 1) == 1;
            call_isr_ack   = ($urandom_range(0, 4) == 0);
            reti_done      = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0: io_addr = PEND;
                1: io_addr = MASK;
                default: io_addr = 6'($urandom_range(0, 63));
            endcase
            io_wr      = ($urandom_range(0, 5) == 0);
            io_data_in = 8'($urandom_range(0, 255));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
